jk_cmd_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the JK storage stage and drives its j, k and enable inputs. A host pushes 2-bit JK commands through a valid/ready port into a 4-entry FIFO. The block applies each command with a programmable setup interval, then a single-cycle enable strobe. It checks the stage's q feedback against an internal reference model and flags any mismatch with a sticky error.

---
 rtl/jk_cmd_sequencer.sv | 145 ++++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_sequencer.sv
// rtl/jk_cmd_sequencer.sv - JK command FIFO and sequencer with setup/strobe timing and q_fb checking
// Queued 2-bit JK commands are applied as j/k, held for SETUP_CYCLES, strobed once, then q_fb is checked.
module jk_cmd_sequencer #(
  parameter int DEPTH        = 4,
  parameter int SETUP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd,
  output logic                     cmd_ready,
  input  logic                     clr_err,
  input  logic                     q_fb,
  output logic                     j,
  output logic                     k,
  output logic                     en,
  output logic                     busy,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = ($clog2(SETUP_CYCLES) > 0) ? $clog2(SETUP_CYCLES) : 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, CHECK} state_t;

  state_t          state_q, state_d;
  logic [1:0]      mem_q [DEPTH];
  logic [1:0]      mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            j_q, j_d;
  logic            k_q, k_d;
  logic            en_q, en_d;
  logic            err_q, err_d;
  logic            exp_q, exp_d;
  logic            push;
  logic            pop;

  assign cmd_ready = (level_q < DEPTH_L);
  assign busy      = (state_q != IDLE) || (level_q != '0);
  assign level     = level_q;
  assign j         = j_q;
  assign k         = k_q;
  assign en        = en_q;
  assign err       = err_q;

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    j_d      = j_q;
    k_d      = k_q;
    en_d     = 1'b0;
    exp_d    = exp_q;
    err_d    = clr_err ? 1'b0 : err_q;
    pop      = 1'b0;
    push     = cmd_valid && cmd_ready;

    if (push) begin
      mem_d[wr_ptr_q] = cmd;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          j_d     = mem_q[rd_ptr_q][1];
          k_d     = mem_q[rd_ptr_q][0];
          cnt_d   = CW'(SETUP_CYCLES - 1);
          state_d = SETUP;
        end
      end
      SETUP: begin
        // en is registered, so it is raised on the edge that enters STROBE
        if (cnt_q == '0) begin
          en_d    = 1'b1;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STROBE: begin
        case ({j_q, k_q})
          2'b01:   exp_d = 1'b0;
          2'b10:   exp_d = 1'b1;
          2'b11:   exp_d = ~exp_q;
          default: exp_d = exp_q;
        endcase
        state_d = CHECK;
      end
      CHECK: begin
        // a mismatch overrides a simultaneous clr_err
        if (q_fb != exp_q) err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'b00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      en_q     <= 1'b0;
      err_q    <= 1'b0;
      exp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      j_q      <= j_d;
      k_q      <= k_d;
      en_q     <= en_d;
      err_q    <= err_d;
      exp_q    <= exp_d;
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb/tb_jk_cmd_sequencer.sv - self-checking bench for jk_cmd_sequencer with a JK stage model and strobe scoreboard
module tb_jk_cmd_sequencer;

  typedef struct {
    logic [1:0] c;
    logic       q;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       cmd_ready;
  logic       clr_err = 1'b0;
  logic       q_fb;
  logic       j, k, en, busy, err;
  logic [2:0] level;

  logic       cmd_valid_b = 1'b0;
  logic [1:0] cmd_b = 2'b00;
  logic       cmd_ready_b;
  logic       clr_err_b = 1'b0;
  logic       q_fb_b;
  logic       j_b, k_b, en_b, busy_b, err_b;
  logic [2:0] level_b;

  logic       q_st = 1'b0;
  logic       q_st_b = 1'b0;
  logic       force0 = 1'b0;
  logic       m_q = 1'b0;
  logic       pend = 1'b0;
  logic       pend_q = 1'b0;
  ent_t       sb[$];
  ent_t       e_mon;
  logic [1:0] sb_b[$];
  int         strobe_cyc[$];
  logic       q_hist[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  jk_cmd_sequencer #(.DEPTH(4), .SETUP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .clr_err(clr_err), .q_fb(q_fb), .j(j), .k(k), .en(en), .busy(busy), .err(err), .level(level)
  );

  jk_cmd_sequencer #(.DEPTH(4), .SETUP_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd(cmd_b), .cmd_ready(cmd_ready_b),
    .clr_err(clr_err_b), .q_fb(q_fb_b), .j(j_b), .k(k_b), .en(en_b), .busy(busy_b), .err(err_b),
    .level(level_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // JK storage stage models driven by each sequencer
  always @(posedge clk or posedge rst) begin
    if (rst) q_st <= 1'b0;
    else if (en) begin
      case ({j, k})
        2'b01:   q_st <= 1'b0;
        2'b10:   q_st <= 1'b1;
        2'b11:   q_st <= ~q_st;
        default: q_st <= q_st;
      endcase
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) q_st_b <= 1'b0;
    else if (en_b) begin
      case ({j_b, k_b})
        2'b01:   q_st_b <= 1'b0;
        2'b10:   q_st_b <= 1'b1;
        2'b11:   q_st_b <= ~q_st_b;
        default: q_st_b <= q_st_b;
      endcase
    end
  end

  assign q_fb   = force0 ? 1'b0 : q_st;
  assign q_fb_b = q_st_b;

  function automatic logic jk_next(input logic q, input logic [1:0] c);
    case (c)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    m_q  = 1'b0;
    pend = 1'b0;
    #2;
    rst = 1'b0;
  endtask

  task automatic push_a(input logic [1:0] c, output int acc_cyc);
    int t;
    t = 0;
    cmd_valid = 1'b1;
    cmd = c;
    while (!cmd_ready && t < 50) begin
      step();
      t++;
    end
    chk("push_a_timeout", t < 50, 1);
    m_q = jk_next(m_q, c);
    sb.push_back('{c, m_q});
    step();
    acc_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic push_b(input logic [1:0] c, output int acc_cyc);
    int t;
    t = 0;
    cmd_valid_b = 1'b1;
    cmd_b = c;
    while (!cmd_ready_b && t < 50) begin
      step();
      t++;
    end
    chk("push_b_timeout", t < 50, 1);
    sb_b.push_back(c);
    step();
    acc_cyc = cyc;
    cmd_valid_b = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 200) begin
      step();
      t++;
    end
    chk("drain_timeout", t < 200, 1);
  endtask

  // Scoreboard monitor: every strobe must match the next pushed command, and the stage q must then follow the model
  always @(posedge clk) begin
    #1;
    if (pend) begin
      chk("q_after_strobe", q_st, pend_q);
      q_hist.push_back(q_st);
      pend = 1'b0;
    end
    if (en) begin
      strobe_cyc.push_back(cyc);
      chk("strobe_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e_mon = sb.pop_front();
        chk("strobe_jk", {j, k}, e_mon.c);
        pend   = 1'b1;
        pend_q = e_mon.q;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, p1, pl;
    int bc[$];
    logic [1:0] fill_cmds[6];
    logic exp_hist[5];
    logic [1:0] bexp;

    fill_cmds = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b11};
    exp_hist  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    #3;
    do_reset();
    chk("rst_j", j, 0);
    chk("rst_k", k, 0);
    chk("rst_en", en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", cmd_ready, 1);
    step();

    // Single set command latency
    push_a(2'b10, e0);
    chk("set_level_after_push", level, 1);
    chk("set_busy_after_push", busy, 1);
    step();
    chk("set_j_at_pop", j, 1);
    chk("set_k_at_pop", k, 0);
    chk("set_level_at_pop", level, 0);
    chk("set_en_pop", en, 0);
    step();
    chk("set_en_pop1", en, 0);
    step();
    chk("set_en_pop2", en, 1);
    step();
    chk("set_en_pop3", en, 0);
    chk("set_busy_check", busy, 1);
    step();
    chk("set_busy_done", busy, 0);
    chk("set_err", err, 0);

    // Fill and overflow with cmd_valid held across pushes
    strobe_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      push_a(fill_cmds[i], pl);
      if (i == 0) p1 = pl;
      if (i == 4) begin
        chk("fill_level_full", level, 4);
        chk("fill_ready_full", cmd_ready, 0);
      end
    end
    chk("fill_sixth_accept_cycle", pl - p1, 7);
    wait_idle();
    chk("fill_strobe_count", strobe_cyc.size(), 6);
    for (int i = 1; i < 6 && i < strobe_cyc.size(); i++)
      chk("fill_strobe_gap", strobe_cyc[i] - strobe_cyc[i-1], 5);
    chk("fill_err", err, 0);

    // Toggle model from reset
    do_reset();
    step();
    q_hist.delete();
    push_a(2'b11, pl);
    push_a(2'b11, pl);
    push_a(2'b00, pl);
    push_a(2'b01, pl);
    push_a(2'b11, pl);
    wait_idle();
    step();
    chk("toggle_hist_len", q_hist.size(), 5);
    for (int i = 0; i < 5 && i < q_hist.size(); i++)
      chk("toggle_q_seq", q_hist[i], exp_hist[i]);
    chk("toggle_err", err, 0);

    // Mismatch, stickiness and clear
    force0 = 1'b1;
    push_a(2'b10, e0);
    repeat (4) step();
    chk("mm_err_before_check", err, 0);
    step();
    chk("mm_err_set", err, 1);
    force0 = 1'b0;
    push_a(2'b01, pl);
    wait_idle();
    chk("mm_err_sticky", err, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("mm_err_cleared", err, 0);
    force0 = 1'b1;
    push_a(2'b10, e0);
    repeat (4) step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("mm_clr_loses", err, 1);
    force0 = 1'b0;
    wait_idle();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("mm_err_final_clear", err, 0);

    // Asynchronous reset while in SETUP with commands queued
    push_a(2'b11, pl);
    push_a(2'b01, pl);
    push_a(2'b10, pl);
    chk("mid_j_before", j, 1);
    chk("mid_k_before", k, 1);
    chk("mid_level_before", level, 2);
    #3;
    rst = 1'b1;
    sb.delete();
    m_q  = 1'b0;
    pend = 1'b0;
    #1;
    chk("mid_en", en, 0);
    chk("mid_j", j, 0);
    chk("mid_k", k, 0);
    chk("mid_level", level, 0);
    chk("mid_busy", busy, 0);
    chk("mid_err", err, 0);
    chk("mid_ready", cmd_ready, 1);
    #1;
    rst = 1'b0;
    strobe_cyc.delete();
    repeat (20) step();
    chk("mid_no_strobe", strobe_cyc.size(), 0);

    // SETUP_CYCLES=1 instance: latency and throughput
    push_b(2'b10, e0);
    push_b(2'b01, pl);
    for (int i = 0; i < 12; i++) begin
      if (en_b) begin
        bc.push_back(cyc);
        bexp = (sb_b.size() != 0) ? sb_b.pop_front() : 2'bxx;
        chk("b_strobe_jk", {j_b, k_b}, bexp);
      end
      step();
    end
    chk("b_strobe_count", bc.size(), 2);
    if (bc.size() == 2) begin
      chk("b_first_strobe", bc[0] - e0, 2);
      chk("b_gap", bc[1] - bc[0], 4);
    end
    chk("b_busy_done", busy_b, 0);
    chk("b_err", err_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
